// File: rtl/l2_cache_test_pkg.sv
// Shared types and address layout for the L2 cache slice.
// MESI/snoop encodings, FSM state type and line helpers.
package l2_cache_test_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  localparam logic [1:0] SNP_ACC = 2'b00;
  localparam logic [1:0] SNP_RD  = 2'b01;
  localparam logic [1:0] SNP_INV = 2'b10;
  localparam logic [1:0] SNP_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT,
    RESPOND
  } state_t;

  localparam int OFF_W    = 3;
  localparam int HALF_BIT = 2;
  localparam int LINE_W   = 64;

  function automatic logic [31:0] selHalf(
    input logic [63:0] line,
    input logic        hi
  );
    return hi ? line[63:32] : line[31:0];
  endfunction

  function automatic logic [63:0] mergeHalf(
    input logic [63:0] line,
    input logic [31:0] word,
    input logic        hi
  );
    return hi ? {word, line[31:0]} : {line[63:32], word};
  endfunction

endpackage

// File: rtl/l2_cache_array.sv
// Direct-mapped tag/state/data store, one read/write port.
// Reads are combinational; only the MESI state is reset.
module l2_cache_array
  import l2_cache_test_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] idx,
  input  logic               we,
  input  logic [TAG_W-1:0]   wTag,
  input  logic [LINE_W-1:0]  wData,
  input  mesi_t              wState,
  output logic [TAG_W-1:0]   rTag,
  output logic [LINE_W-1:0]  rData,
  output mesi_t              rState
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0]  tagMem  [LINES];
  logic [LINE_W-1:0] dataMem [LINES];
  mesi_t             stMem   [LINES];

  // tag and data payload, no reset needed
  always_ff @(posedge clk) begin
    if (we) begin
      tagMem[idx]  <= wTag;
      dataMem[idx] <= wData;
    end
  end

  // coherence state, cleared to I on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        stMem[i] <= MESI_I;
      end
    end else if (we) begin
      stMem[idx] <= wState;
    end
  end

  assign rTag   = tagMem[idx];
  assign rData  = dataMem[idx];
  assign rState = stMem[idx];

endmodule

// File: rtl/l2_cache_test.sv
// Write-back, write-allocate direct-mapped L2 with MESI snoops.
// Controller FSM and hit/miss counters around the line array.
module l2_cache_test
  import l2_cache_test_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stb,
  input  logic              weL1L2,
  input  logic [1:0]        snoop,
  input  logic              addrstbL1L2,
  input  logic [ADDR_W-1:0] addrL1L2,
  output logic              stall,
  output logic              weL2MEM,
  output logic              addrstbL2MEM,
  output logic [ADDR_W-1:0] addrL2MEM,
  inout  wire  [31:0]       dataL1L2,
  inout  wire  [63:0]       dataL2MEM,
  output logic [CNT_W-1:0]  cache_hit_counter,
  output logic [CNT_W-1:0]  cache_miss_counter
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;

  state_t state, stateNext;

  logic [ADDR_W-1:HALF_BIT] addrQ;
  logic                     weQ;
  logic [1:0]               snoopQ;
  logic [31:0]              wdataQ;
  logic [31:0]              rdataQ;
  logic [CNT_W-1:0]         hitCnt;
  logic [CNT_W-1:0]         missCnt;

  logic [TAG_W-1:0]   lineTag;
  logic [INDEX_W-1:0] idx;
  logic               hi;
  logic               hit;
  logic               isAcc;

  logic [TAG_W-1:0]  rTag;
  logic [LINE_W-1:0] rData;
  mesi_t             rState;

  logic              arrWe;
  logic [TAG_W-1:0]  arrTag;
  logic [LINE_W-1:0] arrData;
  mesi_t             arrState;

  logic        hitInc;
  logic        missInc;
  logic        rdLoad;
  logic [31:0] rdVal;

  assign lineTag = addrQ[ADDR_W-1 -: TAG_W];
  assign idx     = addrQ[OFF_W +: INDEX_W];
  assign hi      = addrQ[HALF_BIT];
  assign hit     = (rState != MESI_I) && (rTag == lineTag);
  assign isAcc   = (snoopQ == SNP_ACC);

  l2_cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) uArray (
    .clk    (clk),
    .reset  (reset),
    .idx    (idx),
    .we     (arrWe),
    .wTag   (arrTag),
    .wData  (arrData),
    .wState (arrState),
    .rTag   (rTag),
    .rData  (rData),
    .rState (rState)
  );

  // state, request latch, read-data holding reg and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addrQ   <= '0;
      weQ     <= 1'b0;
      snoopQ  <= SNP_ACC;
      wdataQ  <= '0;
      rdataQ  <= '0;
      hitCnt  <= '0;
      missCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && addrstbL1L2) begin
        addrQ  <= addrL1L2[ADDR_W-1:HALF_BIT];
        weQ    <= weL1L2;
        snoopQ <= snoop;
        if (weL1L2) begin
          wdataQ <= dataL1L2;
        end
      end
      if (rdLoad) begin
        rdataQ <= rdVal;
      end
      if (hitInc) begin
        hitCnt <= hitCnt + CNT_W'(1);
      end
      if (missInc) begin
        missCnt <= missCnt + CNT_W'(1);
      end
    end
  end

  // next state, line updates and counter events
  always_comb begin
    stateNext = state;
    arrWe     = 1'b0;
    arrTag    = rTag;
    arrData   = rData;
    arrState  = rState;
    hitInc    = 1'b0;
    missInc   = 1'b0;
    rdLoad    = 1'b0;
    rdVal     = selHalf(rData, hi);
    unique case (state)
      IDLE: begin
        if (addrstbL1L2) begin
          stateNext = LOOKUP;
        end
      end
      LOOKUP: begin
        if (isAcc) begin
          if (hit) begin
            hitInc    = 1'b1;
            rdLoad    = 1'b1;
            stateNext = RESPOND;
            if (weQ) begin
              arrWe    = 1'b1;
              arrData  = mergeHalf(rData, wdataQ, hi);
              arrState = MESI_M;
            end
          end else begin
            missInc   = 1'b1;
            stateNext = (rState == MESI_M) ? WB_REQ : FILL_REQ;
          end
        end else if (hit && (snoopQ == SNP_RD || snoopQ == SNP_INV)) begin
          if (rState == MESI_M) begin
            stateNext = WB_REQ;
          end else begin
            arrWe     = 1'b1;
            arrState  = (snoopQ == SNP_INV) ? MESI_I : MESI_S;
            stateNext = RESPOND;
          end
        end else begin
          stateNext = RESPOND;
        end
      end
      WB_REQ: stateNext = WB_WAIT;
      WB_WAIT: begin
        if (stb) begin
          if (isAcc) begin
            stateNext = FILL_REQ;
          end else begin
            arrWe     = 1'b1;
            arrState  = (snoopQ == SNP_RD) ? MESI_S : MESI_I;
            stateNext = RESPOND;
          end
        end
      end
      FILL_REQ: stateNext = FILL_WAIT;
      FILL_WAIT: begin
        if (stb) begin
          arrWe     = 1'b1;
          arrTag    = lineTag;
          arrData   = weQ ? mergeHalf(dataL2MEM, wdataQ, hi) : dataL2MEM;
          arrState  = weQ ? MESI_M : MESI_E;
          rdLoad    = 1'b1;
          rdVal     = selHalf(dataL2MEM, hi);
          stateNext = RESPOND;
        end
      end
      RESPOND: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign stall = (state != IDLE) && (state != RESPOND);

  assign addrstbL2MEM = (state == WB_REQ) || (state == FILL_REQ);
  assign weL2MEM      = (state == WB_REQ) || (state == WB_WAIT);

  // victim address while writing back, request line while filling
  always_comb begin
    addrL2MEM = '0;
    if (state == WB_REQ || state == WB_WAIT) begin
      addrL2MEM = {rTag, idx, {OFF_W{1'b0}}};
    end else if (state == FILL_REQ || state == FILL_WAIT) begin
      addrL2MEM = {lineTag, idx, {OFF_W{1'b0}}};
    end
  end

  assign dataL2MEM = weL2MEM ? rData : 'z;
  assign dataL1L2  = (state == RESPOND && isAcc && !weQ) ? rdataQ : 'z;

  assign cache_hit_counter  = hitCnt;
  assign cache_miss_counter = missCnt;

endmodule

// File: tb/tb_l2_cache_test.sv
// Randomized bench for l2_cache_test against a line-level model.
// The bench also plays the L1 and the memory side.
module tb_l2_cache_test;

  logic        clk = 1'b0;
  logic        reset;
  logic        stb;
  logic        weL1L2;
  logic [1:0]  snoop;
  logic        addrstbL1L2;
  logic [31:0] addrL1L2;
  wire         stall;
  wire         weL2MEM;
  wire         addrstbL2MEM;
  wire  [31:0] addrL2MEM;
  wire  [31:0] dataL1L2;
  wire  [63:0] dataL2MEM;
  wire  [31:0] hitCntO;
  wire  [31:0] missCntO;

  logic        l1Drv;
  logic [31:0] l1Val;
  logic        memDrv;
  logic [63:0] memVal;

  assign dataL1L2  = l1Drv  ? l1Val  : 'z;
  assign dataL2MEM = memDrv ? memVal : 'z;

  l2_cache_test dut (
    .clk                (clk),
    .reset              (reset),
    .stb                (stb),
    .weL1L2             (weL1L2),
    .snoop              (snoop),
    .addrstbL1L2        (addrstbL1L2),
    .addrL1L2           (addrL1L2),
    .stall              (stall),
    .weL2MEM            (weL2MEM),
    .addrstbL2MEM       (addrstbL2MEM),
    .addrL2MEM          (addrL2MEM),
    .dataL1L2           (dataL1L2),
    .dataL2MEM          (dataL2MEM),
    .cache_hit_counter  (hitCntO),
    .cache_miss_counter (missCntO)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: memory by line address, lines by index (0=I 1=S 2=E 3=M)
  logic [63:0] mem [logic [31:0]];
  int          mSt   [256];
  logic [20:0] mTag  [256];
  logic [63:0] mData [256];
  int unsigned mHits;
  int unsigned mMiss;

  function automatic logic [63:0] memGet(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] d,
                                        input logic [31:0] w, input bit h);
    logic [63:0] r;
    r = d;
    if (h) r[63:32] = w;
    else   r[31:0]  = w;
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 256; i++) mSt[i] = 0;
    mHits = 0;
    mMiss = 0;
  endtask

  task automatic access(input logic [31:0] a, input logic w,
                        input logic [1:0] sn, input logic [31:0] wd,
                        output logic [31:0] rd);
    int          ix;
    logic [20:0] tg;
    bit          h, hit;
    int          expWb, expFill;
    logic [31:0] expWbA, expFillA, expRd;
    logic [63:0] expWbD, ld;
    int          wbSeen, fillSeen, stallCyc, cnt;
    logic [31:0] wbA, fillA, pendA;
    logic [63:0] wbD;
    bit          done, pend, pendWb, wbFirst, anyReq;
    ix = int'(a[10:3]);
    tg = a[31:11];
    h  = a[2];
    hit = (mSt[ix] != 0) && (mTag[ix] == tg);
    expWb = 0; expFill = 0; expRd = '0;
    expWbA = '0; expWbD = '0; expFillA = '0;
    if (sn == 2'b00) begin
      if (hit) begin
        mHits++;
        if (w) begin
          mData[ix] = merge(mData[ix], wd, h);
          mSt[ix] = 3;
        end
      end else begin
        mMiss++;
        if (mSt[ix] == 3) begin
          expWb = 1;
          expWbA = {mTag[ix], a[10:3], 3'b000};
          expWbD = mData[ix];
          mem[expWbA] = expWbD;
        end
        expFill = 1;
        expFillA = {a[31:3], 3'b000};
        ld = memGet(expFillA);
        mTag[ix] = tg;
        mData[ix] = w ? merge(ld, wd, h) : ld;
        mSt[ix] = w ? 3 : 2;
      end
      expRd = h ? mData[ix][63:32] : mData[ix][31:0];
    end else if (hit && (sn == 2'b01 || sn == 2'b10)) begin
      if (mSt[ix] == 3) begin
        expWb = 1;
        expWbA = {a[31:3], 3'b000};
        expWbD = mData[ix];
        mem[expWbA] = expWbD;
      end
      mSt[ix] = (sn == 2'b10) ? 0 : 1;
    end
    addrL1L2 = a; weL1L2 = w; snoop = sn; addrstbL1L2 = 1'b1;
    l1Drv = w; l1Val = wd;
    @(posedge clk); @(negedge clk);
    addrstbL1L2 = 1'b0; l1Drv = 1'b0;
    wbSeen = 0; fillSeen = 0; stallCyc = 0; cnt = 0;
    wbA = '0; wbD = '0; fillA = '0; pendA = '0; rd = '0;
    done = 0; pend = 0; pendWb = 0; wbFirst = 0; anyReq = 0;
    for (int c = 0; c < 60; c++) begin
      if (!stall) begin
        done = 1;
        rd = dataL1L2;
        break;
      end
      stallCyc++;
      if (stb) begin stb = 1'b0; memDrv = 1'b0; end
      if (pend) begin
        if (cnt == 0) begin
          stb = 1'b1;
          if (!pendWb) begin memDrv = 1'b1; memVal = memGet(pendA); end
          pend = 0;
        end else cnt--;
      end
      if (addrstbL2MEM) begin
        if (!anyReq) wbFirst = weL2MEM;
        anyReq = 1;
        if (weL2MEM) begin
          wbSeen++; wbA = addrL2MEM; wbD = dataL2MEM;
        end else begin
          fillSeen++; fillA = addrL2MEM;
        end
        pend = 1; pendWb = weL2MEM; pendA = addrL2MEM;
        cnt = $urandom_range(0, 2);
      end
      @(posedge clk); @(negedge clk);
    end
    stb = 1'b0; memDrv = 1'b0;
    check("respond timeout", done, 1'b1);
    check("wb count", wbSeen, expWb);
    check("fill count", fillSeen, expFill);
    if (expWb != 0) begin
      check("wb addr", wbA, expWbA);
      check("wb data", wbD, expWbD);
      check("wb before fill", wbFirst, 1'b1);
    end
    if (expFill != 0) check("fill addr", fillA, expFillA);
    if (sn == 2'b00 && !w) check("read data", rd, expRd);
    if (sn == 2'b00 && hit) check("hit stall cycles", stallCyc, 1);
    @(posedge clk); @(negedge clk);
    check("hit counter", hitCntO, mHits);
    check("miss counter", missCntO, mMiss);
  endtask

  logic [31:0] rd;
  int          bad;
  bit          seen;

  initial begin
    reset = 1'b1; stb = 1'b0; weL1L2 = 1'b0; snoop = 2'b00;
    addrstbL1L2 = 1'b0; addrL1L2 = '0;
    l1Drv = 1'b0; l1Val = '0; memDrv = 1'b0; memVal = '0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall", stall, 1'b0);
    check("reset hit cnt", hitCntO, 0);
    check("reset miss cnt", missCntO, 0);
    check("reset mem strobe", addrstbL2MEM, 1'b0);
    check("reset mem we", weL2MEM, 1'b0);
    check("reset mem addr", addrL2MEM, 0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    mem[32'h0000_0100] = 64'h1111_2222_3333_4444;
    access(32'h0000_0100, 1'b0, 2'b00, '0, rd);
    check("first fill data", rd, 32'h3333_4444);
    access(32'h0000_0104, 1'b0, 2'b00, '0, rd);
    check("hit high half", rd, 32'h1111_2222);
    access(32'h0000_0100, 1'b1, 2'b00, 32'hDEAD_BEEF, rd);
    access(32'h0000_0900, 1'b0, 2'b00, '0, rd);
    check("evicted line", mem[32'h0000_0100], 64'h1111_2222_DEAD_BEEF);
    access(32'h0000_0904, 1'b1, 2'b00, 32'hCAFE_F00D, rd);
    access(32'h0000_0900, 1'b0, 2'b10, '0, rd);
    access(32'h0000_0900, 1'b0, 2'b00, '0, rd);
    access(32'h0000_0900, 1'b1, 2'b00, 32'h0BAD_CAFE, rd);
    access(32'h0000_0900, 1'b0, 2'b01, '0, rd);
    access(32'h0000_0904, 1'b0, 2'b00, '0, rd);
    access(32'h0000_0900, 1'b0, 2'b11, '0, rd);

    addrL1L2 = 32'h0000_0400; weL1L2 = 1'b0; snoop = 2'b00;
    addrstbL1L2 = 1'b1;
    @(posedge clk); @(negedge clk);
    addrstbL1L2 = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (addrstbL2MEM) seen = 1;
      else begin @(posedge clk); @(negedge clk); end
    end
    check("fill req before reset", seen, 1'b1);
    @(posedge clk); @(negedge clk);
    check("stall in fill wait", stall, 1'b1);
    reset = 1'b1; stb = 1'b1; memDrv = 1'b1; memVal = 64'h5555_6666_7777_8888;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("mid reset stall", stall, 1'b0);
    check("mid reset hit cnt", hitCntO, 0);
    check("mid reset miss cnt", missCntO, 0);
    check("mid reset mem strobe", addrstbL2MEM, 1'b0);
    check("mid reset mem addr", addrL2MEM, 0);
    bad = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (addrstbL2MEM || stall) bad++;
    end
    stb = 1'b0; memDrv = 1'b0;
    check("stb ignored after reset", bad, 0);
    modelReset();
    access(32'h0000_0100, 1'b0, 2'b00, '0, rd);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [1:0]  sn;
      a = {19'h0, 2'($urandom_range(0, 3)), 6'h0,
           2'($urandom_range(0, 3)), 1'($urandom), 2'b00};
      sn = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      access(a, 1'($urandom), sn, $urandom, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_cache_test.md
L2_CACHE_TEST -- requirements
Module: l2_cache_test

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, byte address width; INDEX_W, 8, set index bits (256 lines); CNT_W, 32, counter width.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stb  in  1  memory done strobe; read data valid / write accepted in this cycle.
REQ-005 weL1L2  in  1  L1 request type: 1 = write, 0 = read.
REQ-006 snoop  in  2  00 access; 01 bus-read snoop; 10 bus-invalidate snoop; 11 reserved.
REQ-007 addrstbL1L2  in  1  L1 request strobe, one cycle.
REQ-008 addrL1L2  in  32  L1 byte address.
REQ-009 stall  out  1  busy; L1 holds its request and waits while high.
REQ-010 weL2MEM  out  1  memory request type: 1 = write-back, 0 = fill read.
REQ-011 addrstbL2MEM  out  1  memory request strobe, one cycle.
REQ-012 addrL2MEM  out  32  memory line address, bits [2:0] zero.
REQ-013 dataL1L2  inout  32  L1 data bus; L1 drives on writes, block drives on reads in RESPOND only.
REQ-014 dataL2MEM  inout  64  memory bus; block drives during write-back until stb, else high-Z.
REQ-015 cache_hit_counter, cache_miss_counter  out  CNT_W  access hit/miss totals.

Function
REQ-016 Organisation SHALL be direct-mapped, write-back, write-allocate; line = 8 bytes = one memory word; offset addr[2:0], index addr[10:3], tag addr[31:11].
REQ-017 Each line SHALL hold tag, 64-bit data, 2-bit MESI state (I=00, S=01, E=10, M=11).
REQ-018 FSM states SHALL be IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESPOND.
REQ-019 IDLE SHALL sample addrstbL1L2 and latch address, weL1L2, snoop and (on writes) dataL1L2; next state LOOKUP; strobe ignored in any other state.
REQ-020 stall SHALL be 1 in LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT; 0 in IDLE and RESPOND.
REQ-021 Access hit (tag match, state != I): read returns addr[2] ? data[63:32] : data[31:0]; write merges that half and sets M; hit counter +1; LOOKUP -> RESPOND -> IDLE (hit latency 2 cycles after strobe).
REQ-022 Access miss: miss counter +1; victim in M goes WB_REQ, otherwise FILL_REQ.
REQ-023 WB_REQ SHALL pulse addrstbL2MEM=1, weL2MEM=1, addrL2MEM={victim tag, index, 000} for one cycle and drive victim data; WB_WAIT holds data until stb, then FILL_REQ.
REQ-024 FILL_REQ SHALL pulse addrstbL2MEM=1, weL2MEM=0 with the request line address; FILL_WAIT captures dataL2MEM when stb=1, installs read miss as E, write miss (merged) as M, then RESPOND.
REQ-025 Snoop 01: M line written back (WB path), then S; E -> S; S/I unchanged. Snoop 10: M written back then I; S/E -> I. Snoop 11 or miss: no change. Snoops SHALL NOT change counters; snoops end in RESPOND without driving data.
REQ-026 Counters SHALL wrap modulo 2^CNT_W; stb outside WB_WAIT/FILL_WAIT SHALL be ignored.
REQ-027 dataL1L2 SHALL be driven only in RESPOND of a read access; all other cycles high-Z.

Reset
REQ-028 Reset SHALL set state IDLE, all lines I, counters 0, stall=0, addrstbL2MEM=0, weL2MEM=0, addrL2MEM=0, both data buses high-Z.
REQ-029 Reset mid-operation SHALL abandon any write-back/fill with no further memory strobes; reset dominates simultaneous strobes.

Structure
REQ-030 A shared package SHALL hold MESI encodings, snoop encodings, FSM state type, and address field widths/positions.
REQ-031 One sub-module, l2_cache_array (tag/state/data storage, one read/write port), is natural; FSM and counters stay in the top.

Verification
REQ-032 After reset, read 0x0000_0100 -> miss=1, fill request addr 0x0000_0100, memory returns 0x1111_2222_3333_4444 -> L1 gets 0x3333_4444, line E.
REQ-033 Read 0x0000_0104 next -> hit=1, data 0x1111_2222, stall high exactly one cycle.
REQ-034 Write 0xDEAD_BEEF to 0x0000_0100 -> hit=2, line M; then read 0x0000_0900 (same index) -> write-back to 0x0000_0100 with 0x1111_2222_DEAD_BEEF before the fill.
REQ-035 Snoop 10 on a line in M -> write-back issued, line I; later access to it misses; counters unchanged by the snoop.
REQ-036 Assert reset during FILL_WAIT -> IDLE next cycle, stall=0, counters 0, subsequent stb ignored.
